// File: rtl/temp_conv_pkg.sv
// Shared constants and state encoding for the Fahrenheit -> Celsius converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package temp_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } conv_state_e;

  localparam int F_OFFSET   = 32;   // 0 C in Fahrenheit
  localparam int C_MAX      = 100;  // Celsius at the top of the legal range
  localparam int NUM_W      = 10;   // dividend width, holds up to 904
  localparam int DIVISOR    = 9;
  localparam int SCALE      = 5;    // C = (F - 32) * 5 / 9
  localparam int ROUND_BIAS = 4;    // floor((x + 4) / 9) rounds x/9 half up

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider by a constant, one quotient bit per cycle.
// Latency: start edge loads the dividend, then DVD_W busy cycles; done marks the final one.
// Backpressure: none; caller must not pulse start while busy (start simply reloads).
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   start       load dividend and begin; sampled on the rising edge
//   dividend    DVD_W-bit unsigned dividend
//   busy        iterations in progress
//   done        high during the last iteration; quotient is final after that edge
//   quotient    DVD_W-bit quotient, valid once busy has dropped
module seq_divider
  import temp_conv_pkg::*;
#(
  parameter int DVD_W = NUM_W,
  parameter int DVSR  = DIVISOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  // Partial remainder is always < DVSR, so clog2(DVSR) bits suffice.
  localparam int REM_W = $clog2(DVSR);
  localparam int CNT_W = $clog2(DVD_W);
  localparam logic [REM_W:0]   DVSR_T = (REM_W+1)'(DVSR);
  localparam logic [REM_W-1:0] DVSR_R = REM_W'(DVSR);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DVD_W - 1);

  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_nxt;
  logic [REM_W:0]   trial;
  logic [DVD_W-1:0] quot_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             bit_ge;

  // quot_q doubles as the dividend shift register: dividend bits leave at the
  // MSB while quotient bits enter at the LSB.
  always_comb begin
    trial  = {rem_q, quot_q[DVD_W-1]};
    bit_ge = (trial >= DVSR_T);
    // The true difference is < DVSR, so modulo-2^REM_W subtraction is exact.
    rem_nxt = bit_ge ? (trial[REM_W-1:0] - DVSR_R) : trial[REM_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_nxt;
      quot_q <= {quot_q[DVD_W-2:0], bit_ge};
      cnt_q  <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign quotient = quot_q;

endmodule

// File: rtl/f_to_c_converter.sv
// Fahrenheit -> Celsius converter: clamp/range check, (F-32)*5+4, sequential divide by 9.
// Latency: out_valid rises 11 edges after the accept edge for every input; 13-cycle min period.
// Backpressure: one conversion in flight; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk, rst_n            clock and async active-low reset
//   in_valid / in_ready   request handshake; fahr sampled on the accept edge only
//   fahr                  IN_W-bit unsigned Fahrenheit
//   out_valid / out_ready result handshake
//   celsius               rounded Celsius, clamped to [0, C_MAX]
//   range_err             input was outside [F_MIN, F_MAX]
module f_to_c_converter
  import temp_conv_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int F_MIN = F_OFFSET,
  parameter int F_MAX = F_OFFSET + (C_MAX * DIVISOR) / SCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  fahr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] celsius,
  output logic             range_err
);

  localparam logic [IN_W-1:0]  F_MIN_V = IN_W'(F_MIN);
  localparam logic [IN_W-1:0]  F_MAX_V = IN_W'(F_MAX);
  localparam logic [NUM_W-1:0] SCALE_V = NUM_W'(SCALE);
  localparam logic [NUM_W-1:0] BIAS_V  = NUM_W'(ROUND_BIAS);
  // Dividend used for inputs above F_MAX: the same value F_MAX itself yields.
  localparam logic [NUM_W-1:0] NUM_SAT = NUM_W'((F_MAX - F_MIN) * SCALE + ROUND_BIAS);

  conv_state_e state_q;
  conv_state_e state_d;

  logic [IN_W-1:0]  fahr_q;
  logic             below_q;
  logic             above_q;
  logic [IN_W-1:0]  fahr_diff;
  logic [NUM_W-1:0] num_lin;
  logic [NUM_W-1:0] num;
  logic             div_start;
  logic             div_done;
  logic             div_busy_unused;
  logic [NUM_W-1:0] quot;
  logic [NUM_W-OUT_W-1:0] quot_hi_unused;

  // ---------------------------------------------------------------- input capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fahr_q  <= '0;
      below_q <= 1'b0;
      above_q <= 1'b0;
    end else if (in_valid && (state_q == IDLE)) begin
      fahr_q  <= fahr;
      below_q <= (fahr < F_MIN_V);
      above_q <= (fahr > F_MAX_V);
    end
  end

  // ---------------------------------------------------------------- scale/offset
  // fahr_diff is only meaningful when the input is in range; the clamp mux
  // below discards it otherwise, so the wrap for low inputs is harmless.
  assign fahr_diff = fahr_q - F_MIN_V;
  assign num_lin   = NUM_W'(fahr_diff) * SCALE_V + BIAS_V;

  always_comb begin
    num = num_lin;
    if (below_q) begin
      num = '0;
    end else if (above_q) begin
      num = NUM_SAT;
    end
  end

  // ---------------------------------------------------------------- divider
  seq_divider #(
    .DVD_W (NUM_W),
    .DVSR  (DIVISOR)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num),
    .busy     (div_busy_unused),
    .done     (div_done),
    .quotient (quot)
  );

  // Quotient never exceeds C_MAX, so the bits above OUT_W are always zero.
  assign quot_hi_unused = quot[NUM_W-1:OUT_W];

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = PREP;
        end
      end
      PREP: begin
        div_start = 1'b1;
        state_d   = DIV;
      end
      DIV: begin
        // div_done flags the last iteration, so the quotient is final on
        // the same edge that enters DONE.
        if (div_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Results are masked outside DONE so partial quotients never leak out.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign celsius   = out_valid ? quot[OUT_W-1:0] : '0;
  assign range_err = out_valid && (below_q || above_q);

endmodule
